// File: rtl/output_layer_mac.sv
// Output dense layer: streams N_IN activations, accumulates against two class
// weight vectors, adds biases, rescales by FRAC and saturates to 16-bit scores.
module output_layer_mac #(
    parameter int N_IN  = 16,
    parameter int FRAC  = 8,
    parameter int ACC_W = 40,
    parameter int AW    = $clog2(N_IN+1)+1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [15:0]   act_data,
    input  logic          act_valid,
    output logic          act_ready,
    input  logic          w_we,
    input  logic [AW-1:0] w_addr,
    input  logic [15:0]   w_data,
    output logic [15:0]   score0,
    output logic [15:0]   score1,
    output logic          score_valid,
    output logic          busy
);
    localparam int IW = AW-1;
    localparam int DEPTH = 2**IW;
    localparam logic [IW-1:0] BIAS_IDX = IW'(N_IN);
    localparam logic [IW-1:0] LAST_IDX = IW'(N_IN-1);

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_FINISH, S_OUT} state_t;

    state_t                  state;
    logic [IW-1:0]           cnt;
    logic signed [ACC_W-1:0] acc0, acc1;

    // Index N_IN of each bank holds the class bias; entries above it are never written.
    logic signed [15:0] wmem0 [DEPTH];
    logic signed [15:0] wmem1 [DEPTH];

    logic                    accept;
    logic                    wr_ok;
    logic [IW-1:0]           rd_idx;
    logic signed [31:0]      prod0, prod1;
    logic signed [ACC_W-1:0] prod0_ext, prod1_ext;
    logic signed [ACC_W-1:0] bias0_ext, bias1_ext;
    logic signed [ACC_W-1:0] res0, res1;

    assign act_ready = (state == S_IDLE) || (state == S_ACCUM);
    assign busy      = (state != S_IDLE);
    assign accept    = act_valid && act_ready;
    assign wr_ok     = w_we && (state == S_IDLE) && (w_addr[IW-1:0] <= BIAS_IDX);
    assign rd_idx    = (state == S_IDLE) ? '0 : cnt;

    always_comb begin
        prod0     = $signed(act_data) * wmem0[rd_idx];
        prod1     = $signed(act_data) * wmem1[rd_idx];
        prod0_ext = {{(ACC_W-32){prod0[31]}}, prod0};
        prod1_ext = {{(ACC_W-32){prod1[31]}}, prod1};
        bias0_ext = {{(ACC_W-16){wmem0[BIAS_IDX][15]}}, wmem0[BIAS_IDX]};
        bias1_ext = {{(ACC_W-16){wmem1[BIAS_IDX][15]}}, wmem1[BIAS_IDX]};
        // Arithmetic shift floors toward -inf after the bias is aligned to Q.FRAC.
        res0      = (acc0 + (bias0_ext <<< FRAC)) >>> FRAC;
        res1      = (acc1 + (bias1_ext <<< FRAC)) >>> FRAC;
    end

    function automatic logic [15:0] sat16(input logic signed [ACC_W-1:0] v);
        if (v[ACC_W-1:15] == {(ACC_W-15){v[ACC_W-1]}})
            return v[15:0];
        else
            return v[ACC_W-1] ? 16'h8000 : 16'h7fff;
    endfunction

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            if (w_addr[AW-1]) wmem1[w_addr[IW-1:0]] <= w_data;
            else              wmem0[w_addr[IW-1:0]] <= w_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            acc0        <= '0;
            acc1        <= '0;
            score0      <= '0;
            score1      <= '0;
            score_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        acc0  <= prod0_ext;
                        acc1  <= prod1_ext;
                        cnt   <= IW'(1);
                        state <= (N_IN == 1) ? S_FINISH : S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (accept) begin
                        acc0 <= acc0 + prod0_ext;
                        acc1 <= acc1 + prod1_ext;
                        cnt  <= cnt + IW'(1);
                        if (cnt == LAST_IDX) state <= S_FINISH;
                    end
                end
                S_FINISH: begin
                    score0      <= sat16(res0);
                    score1      <= sat16(res1);
                    score_valid <= 1'b1;
                    state       <= S_OUT;
                end
                S_OUT: begin
                    score_valid <= 1'b0;
                    state       <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_output_layer_mac.sv
// Directed bench for output_layer_mac with a frame-level arithmetic model and
// a per-cycle compare of score_valid/score0/score1 against expected pulses.
module tb_output_layer_mac;
    localparam int N_IN = 4;
    localparam int FRAC = 8;
    localparam int AW   = $clog2(N_IN+1)+1;

    logic          clk = 0;
    logic          reset = 1;
    logic [15:0]   act_data = 0;
    logic          act_valid = 0;
    logic          act_ready;
    logic          w_we = 0;
    logic [AW-1:0] w_addr = 0;
    logic [15:0]   w_data = 0;
    logic [15:0]   score0, score1;
    logic          score_valid, busy;

    output_layer_mac #(.N_IN(N_IN), .FRAC(FRAC), .ACC_W(40), .AW(AW)) dut (
        .clk(clk), .reset(reset), .act_data(act_data), .act_valid(act_valid),
        .act_ready(act_ready), .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
        .score0(score0), .score1(score1), .score_valid(score_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    int n_chk = 0, n_fail = 0;
    task automatic chk(input string name, input longint got, input longint exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, got, exp, edge_n);
        end
    endtask

    // Model state: weights as the block should hold them.
    int mw [2][N_IN];
    int mb [2];

    typedef struct { int when; int s0; int s1; } exp_t;
    exp_t q[$];
    bit   cmp_en = 0;
    bit   have_last = 0;
    int   last0 = 0, last1 = 0;
    int   pulses = 0, frames = 0;

    function automatic int model_score(input int cls, input int a [N_IN]);
        longint s = 0;
        for (int i = 0; i < N_IN; i++) s += longint'(a[i]) * longint'(mw[cls][i]);
        s += longint'(mb[cls]) * (longint'(1) << FRAC);
        s = s >>> FRAC;
        if (s > 32767)  s = 32767;
        if (s < -32768) s = -32768;
        return int'(s);
    endfunction

    always @(negedge clk) begin
        if (cmp_en && !reset) begin
            bit exp_v;
            while (q.size() > 0 && q[0].when < edge_n) void'(q.pop_front());
            exp_v = (q.size() > 0 && q[0].when == edge_n);
            chk("score_valid", score_valid, exp_v);
            if (score_valid) pulses++;
            if (exp_v) begin
                chk("score0", $signed(score0), q[0].s0);
                chk("score1", $signed(score1), q[0].s1);
                last0 = q[0].s0; last1 = q[0].s1; have_last = 1;
                void'(q.pop_front());
            end else if (have_last) begin
                chk("score0_hold", $signed(score0), last0);
                chk("score1_hold", $signed(score1), last1);
            end
        end
    end

    task automatic wr(input int cls, input int idx, input int val);
        w_we = 1; w_addr = AW'((cls << (AW-1)) | idx); w_data = 16'(val);
        @(posedge clk); #1;
        w_we = 0;
        if (idx < N_IN) mw[cls][idx] = val;
        else if (idx == N_IN) mb[cls] = val;
    endtask

    task automatic set_all(input int v0, input int v1);
        for (int i = 0; i < N_IN; i++) begin
            wr(0, i, v0); wr(1, i, v1);
        end
    endtask

    task automatic run_frame(input int a0, input int a1, input int a2, input int a3,
                             input int gap, input logic do_wr, input logic [AW-1:0] wa,
                             input logic [15:0] wd, output int e0, output int e1);
        int a [N_IN];
        int k;
        a[0] = a0; a[1] = a1; a[2] = a2; a[3] = a3;
        e0 = model_score(0, a);
        e1 = model_score(1, a);
        for (int i = 0; i < N_IN; i++) begin
            if (i > 0) begin
                for (int g = 0; g < gap; g++) begin
                    act_valid = 0; act_data = 16'($urandom);
                    @(negedge clk);
                    chk("busy_gap", busy, 1);
                    @(posedge clk); #1;
                end
            end
            act_valid = 1; act_data = 16'(a[i]);
            if (do_wr && i == 1) begin
                w_we = 1; w_addr = wa; w_data = wd;
            end
            @(negedge clk);
            chk("act_ready_beat", act_ready, 1);
            @(posedge clk); #1;
            w_we = 0;
        end
        act_valid = 0; act_data = 16'($urandom);
        k = edge_n;
        q.push_back('{when: k + 1, s0: e0, s1: e1});
        frames++;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            chk("act_ready_after", act_ready, (j == 2) ? 1 : 0);
        end
        @(posedge clk); #1;
    endtask

    int e0, e1;

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        chk("rst_score0", score0, 0);
        chk("rst_score1", score1, 0);
        chk("rst_valid", score_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", act_ready, 1);
        @(posedge clk); #1;
        have_last = 1; last0 = 0; last1 = 0;
        cmp_en = 1;

        // Basic frame: 1.0 and 0.5 weights, zero biases.
        set_all(256, 128); wr(0, N_IN, 0); wr(1, N_IN, 0);
        run_frame(256, 256, 256, 256, 0, 0, '0, '0, e0, e1);
        chk("t1_model0", e0, 1024);
        chk("t1_model1", e1, 512);
        chk("t1_dut0", $signed(score0), 1024);
        chk("t1_dut1", $signed(score1), 512);

        wr(1, N_IN, 1536);
        run_frame(256, 256, 256, 256, 0, 0, '0, '0, e0, e1);
        chk("t2_model1", e1, 2048);
        chk("t2_dut1", $signed(score1), 2048);

        // Saturation both ways.
        set_all(32512, 32512);
        run_frame(32512, 32512, 32512, 32512, 0, 0, '0, '0, e0, e1);
        chk("sat_pos0", $signed(score0), 32767);
        chk("sat_pos1", $signed(score1), 32767);
        set_all(-32512, -32512);
        run_frame(32512, 32512, 32512, 32512, 0, 0, '0, '0, e0, e1);
        chk("sat_neg0", $signed(score0), -32768);
        chk("sat_neg1", $signed(score1), -32768);

        // Backpressure gaps between beats.
        set_all(256, 128); wr(1, N_IN, 0);
        run_frame(256, 256, 256, 256, 1, 0, '0, '0, e0, e1);
        chk("bp_dut0", $signed(score0), 1024);
        run_frame(256, 256, 256, 256, 3, 0, '0, '0, e0, e1);
        chk("bp3_dut1", $signed(score1), 512);

        // Reset mid-frame: two beats, then reset; no pulse for the aborted frame.
        for (int i = 0; i < 2; i++) begin
            act_valid = 1; act_data = 16'd256;
            @(posedge clk); #1;
        end
        act_valid = 0;
        cmp_en = 0;
        reset = 1;
        last0 = 0; last1 = 0; have_last = 1;
        repeat (2) @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        chk("midrst_busy", busy, 0);
        chk("midrst_score0", score0, 0);
        @(posedge clk); #1;
        cmp_en = 1;
        run_frame(256, 256, 256, 256, 0, 0, '0, '0, e0, e1);
        chk("midrst_dut0", $signed(score0), 1024);

        // Write while busy is dropped; same write in IDLE takes effect.
        run_frame(256, 256, 256, 256, 0, 1, AW'(0), 16'd0, e0, e1);
        chk("busywr_dut0", $signed(score0), 1024);
        run_frame(256, 256, 256, 256, 0, 0, '0, '0, e0, e1);
        chk("busywr_next0", $signed(score0), 1024);
        wr(0, 0, 0);
        run_frame(256, 256, 256, 256, 0, 0, '0, '0, e0, e1);
        chk("idlewr_model0", e0, 768);
        chk("idlewr_dut0", $signed(score0), 768);

        // Mixed signs: floor rounding of a negative result, nonzero bias.
        wr(0, 0, 256); wr(0, 1, -128); wr(0, 2, 77); wr(0, 3, 3);
        wr(1, N_IN, 1536);
        run_frame(-300, 5, 1000, -7, 0, 0, '0, '0, e0, e1);
        chk("mix_model0", e0, -2);
        chk("mix_model1", e1, 1885);
        chk("mix_dut0", $signed(score0), -2);
        chk("mix_dut1", $signed(score1), 1885);

        repeat (4) @(posedge clk);
        #1;
        chk("pulse_count", pulses, frames);
        chk("queue_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/output_layer_mac.md
Name: output_layer_mac

Overview:
Final dense layer of the classifier. It streams in N_IN hidden-layer activations and multiply-accumulates each one against two per-class weight vectors. It then adds per-class biases, rescales and saturates the results to two signed 16-bit class scores. score0/score1/score_valid connect directly to the argmax stage's in0/in1/valid_in.

Parameters:
N_IN, 16, number of activations (beats) per frame; >=1
FRAC, 8, fractional bits of activations, weights and scores (Q(15-FRAC).FRAC)
ACC_W, 40, accumulator width; must be >= 32+clog2(N_IN)+1
AW, clog2(N_IN+1)+1, weight-memory address width

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
act_data  input  16  signed activation, Q.FRAC
act_valid  input  1  activation beat valid
act_ready  output  1  block can accept a beat
w_we  input  1  weight/bias write enable
w_addr  input  AW  {class bit (MSB), index}; index 0..N_IN-1 = weight, index N_IN = bias
w_data  input  16  signed weight or bias, Q.FRAC
score0  output  16  signed class-0 score, Q.FRAC
score1  output  16  signed class-1 score, Q.FRAC
score_valid  output  1  one-cycle pulse: scores valid
busy  output  1  frame in progress (state != IDLE)

Behaviour:
- Reset: state=IDLE; beat counter=0; both accumulators=0; score0=score1=0; score_valid=0; busy=0. Weight/bias storage is not reset and is undefined until written.
- Reset asserted mid-frame: the partial frame is discarded. No score_valid is produced for it. The next frame starts clean.
- States:
  - IDLE: act_ready=1. An accepted beat (act_valid&&act_ready) loads acc_c = act*w[c][0], sets cnt=1, and moves to ACCUM. If N_IN==1, it moves directly to FINISH.
  - ACCUM: act_ready=1. Each accepted beat does acc_c += act*w[c][cnt] for c=0,1 and cnt++. The beat that makes cnt==N_IN moves to FINISH. If act_valid is low, the block holds; there is no timeout.
  - FINISH (1 cycle): act_ready=0. For each class, r_c = (acc_c + (sext(bias_c) << FRAC)) >>> FRAC (arithmetic shift, truncation toward -inf). r_c is saturated to [-32768, 32767] and registered into score_c. score_valid<=1. Next state is OUT.
  - OUT (1 cycle): act_ready=0, score_valid=1. Next state is IDLE and score_valid returns to 0.
- Latency: the last beat is accepted at edge k; score_valid is high in the cycle after edge k+1, for exactly 1 cycle. Minimum frame period is N_IN+2 cycles.
- Scores hold their values after score_valid drops, until the next FINISH.
- Arithmetic: the 16x16 signed product is 32 bits, sign-extended to ACC_W. ACC_W is sized so the accumulator cannot overflow; saturation occurs only at the final rescale.
- Weight writes: accepted only in IDLE, taking effect from the next edge. A write issued while busy=1 is dropped silently. A write in IDLE on the same edge as a first beat is accepted, but the new value is not used by that beat's index-0 product if the write targets index 0.
- An addr index > N_IN is ignored.
- act_data is ignored when act_ready=0.

Test Plan:
- N_IN=4, FRAC=8; w0[*]=256 (1.0), w1[*]=128 (0.5), biases 0; stream act=256 x4 back-to-back -> score0=1024, score1=512, score_valid high exactly 1 cycle, 2 edges after the 4th accepted beat; argmax sees class 0.
- Same weights, bias1=1536 (6.0) -> score0=1024, score1=2048; act_ready low for exactly 2 cycles after the last beat.
- Saturation: all weights 32512, act=32512 x4 -> score0=score1=32767; weights -32512 -> both -32768.
- Backpressure: same data as test 1 with act_valid low for 3 random cycles between beats -> identical scores; cnt advances only on accepted beats.
- Reset asserted after beat 2 of 4, then a full new frame of act=256 -> exactly one score_valid pulse, score0=1024; no pulse is produced for the aborted frame.
- Write w0[0]=0 while busy -> dropped; the current and next frame still use 256 (score0=1024). The same write in IDLE gives score0=768 on the following frame.
